// File: rtl/fir_tap_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : fir_tap_serializer
//  Purpose  : Parallel-to-serial converter for FIR tap vectors. Takes one
//             full tap vector (NB_TAPS words in a single stream beat) and
//             emits it as nb single-word stream beats, forward or reversed.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i               clock, rising edge
//    rst_ni              asynchronous active-low reset
//    clear_i             synchronous soft clear (drops any held vector)
//    nb_taps_i           words to emit per vector (0 or >NB_TAPS -> NB_TAPS)
//    reverse_i           0: word 0 first, 1: word nb-1 first
//    h_parallel_*        sink stream, data word k at [k*DATA_WIDTH +: DATA_WIDTH]
//    h_serial_*          source stream, one tap word per beat
//    busy_o              a vector is held
//    done_o              pulse on the handshake of the last word of a vector
// ============================================================================
module fir_tap_serializer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NB_TAPS    = 50,
  parameter int unsigned CNT_WIDTH  = $clog2(NB_TAPS + 1)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              clear_i,
  input  logic [CNT_WIDTH-1:0]              nb_taps_i,
  input  logic                              reverse_i,
  // parallel sink
  input  logic                              h_parallel_valid_i,
  output logic                              h_parallel_ready_o,
  input  logic [DATA_WIDTH*NB_TAPS-1:0]     h_parallel_data_i,
  input  logic [DATA_WIDTH*NB_TAPS/8-1:0]   h_parallel_strb_i,
  // serial source
  output logic                              h_serial_valid_o,
  input  logic                              h_serial_ready_i,
  output logic [DATA_WIDTH-1:0]             h_serial_data_o,
  output logic [DATA_WIDTH/8-1:0]           h_serial_strb_o,
  // status
  output logic                              busy_o,
  output logic                              done_o
);

  localparam int unsigned          STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [CNT_WIDTH-1:0] NB_MAX     = CNT_WIDTH'(NB_TAPS);
  localparam logic [CNT_WIDTH-1:0] ONE        = CNT_WIDTH'(1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e                            state_q, state_d;
  logic [CNT_WIDTH-1:0]              cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]              nb_q, nb_d;
  logic                              rev_q, rev_d;
  logic [DATA_WIDTH*NB_TAPS-1:0]     vec_q, vec_d;
  logic [STRB_WIDTH*NB_TAPS-1:0]     strb_q, strb_d;

  logic [CNT_WIDTH-1:0]              nb_eff;
  logic [CNT_WIDTH-1:0]              idx;
  logic                              last;
  logic                              serial_hs;
  logic                              accept;

  // Saturate the requested count: 0 and anything above NB_TAPS mean "all".
  always_comb begin
    nb_eff = nb_taps_i;
    if ((nb_taps_i == '0) || (nb_taps_i > NB_MAX)) begin
      nb_eff = NB_MAX;
    end
  end

  // nb_q is never 0 while in SHIFT, so nb_q-1 does not wrap there.
  assign last      = (state_q == SHIFT) && (cnt_q == (nb_q - ONE));
  assign serial_hs = (state_q == SHIFT) && h_serial_ready_i;
  assign idx       = rev_q ? (nb_q - ONE - cnt_q) : cnt_q;

  // Ready also opens on the last serial handshake so vectors can follow
  // each other without an idle bubble.
  assign h_parallel_ready_o = !clear_i &&
                              ((state_q == IDLE) || (last && h_serial_ready_i));
  assign accept             = h_parallel_valid_i && h_parallel_ready_o;

  assign h_serial_valid_o = (state_q == SHIFT);
  assign busy_o           = (state_q == SHIFT);
  assign done_o           = serial_hs && last && !clear_i;

  // Word/strobe select purely from registered state: outputs stay stable
  // while the consumer stalls.
  always_comb begin
    h_serial_data_o = '0;
    h_serial_strb_o = '0;
    if (state_q == SHIFT) begin
      for (int k = 0; k < NB_TAPS; k++) begin
        if (idx == CNT_WIDTH'(k)) begin
          h_serial_data_o = vec_q[k*DATA_WIDTH +: DATA_WIDTH];
          h_serial_strb_o = strb_q[k*STRB_WIDTH +: STRB_WIDTH];
        end
      end
    end
  end

  // Next-state logic; clear overrides any handshake in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nb_d    = nb_q;
    rev_d   = rev_q;
    vec_d   = vec_q;
    strb_d  = strb_q;

    if (clear_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      vec_d   = '0;
      strb_d  = '0;
    end else begin
      if (serial_hs) begin
        if (!last) begin
          cnt_d = cnt_q + ONE;
        end else begin
          state_d = IDLE;
        end
      end
      // An accept on the last beat overrides the return to IDLE above.
      if (accept) begin
        state_d = SHIFT;
        cnt_d   = '0;
        nb_d    = nb_eff;
        rev_d   = reverse_i;
        vec_d   = h_parallel_data_i;
        strb_d  = h_parallel_strb_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      nb_q    <= '0;
      rev_q   <= 1'b0;
      vec_q   <= '0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nb_q    <= nb_d;
      rev_q   <= rev_d;
      vec_q   <= vec_d;
      strb_q  <= strb_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_tap_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_fir_tap_serializer
//  Purpose  : Scoreboard bench for fir_tap_serializer (NB_TAPS=4). Stimulus
//             pushes the expected word ordering on accept; a monitor pops
//             and compares on every serial handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fir_tap_serializer;

  localparam int DW = 16;
  localparam int NT = 4;
  localparam int CW = $clog2(NT + 1);
  localparam int SW = DW / 8;

  logic              clk_i     = 1'b0;
  logic              rst_ni    = 1'b0;
  logic              clear_i   = 1'b0;
  logic [CW-1:0]     nb_taps_i = '0;
  logic              reverse_i = 1'b0;
  logic              par_valid = 1'b0;
  logic              par_ready;
  logic [DW*NT-1:0]  par_data  = '0;
  logic [SW*NT-1:0]  par_strb  = '0;
  logic              ser_valid;
  logic              ser_ready = 1'b1;
  logic [DW-1:0]     ser_data;
  logic [SW-1:0]     ser_strb;
  logic              busy;
  logic              done;

  fir_tap_serializer #(
    .DATA_WIDTH (DW),
    .NB_TAPS    (NT),
    .CNT_WIDTH  (CW)
  ) u_dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .clear_i            (clear_i),
    .nb_taps_i          (nb_taps_i),
    .reverse_i          (reverse_i),
    .h_parallel_valid_i (par_valid),
    .h_parallel_ready_o (par_ready),
    .h_parallel_data_i  (par_data),
    .h_parallel_strb_i  (par_strb),
    .h_serial_valid_o   (ser_valid),
    .h_serial_ready_i   (ser_ready),
    .h_serial_data_o    (ser_data),
    .h_serial_strb_o    (ser_strb),
    .busy_o             (busy),
    .done_o             (done)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic          last;
  } exp_t;

  exp_t          exp_q[$];
  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  int            beat_cyc[$];
  logic [DW-1:0] beat_data[$];
  int            done_cnt = 0;
  int            busy_cnt = 0;
  bit            stall_mode = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: the words a vector must produce, in emission order.
  task automatic model_push(input logic [DW*NT-1:0] v, input logic [SW*NT-1:0] s,
                            input int n, input bit rev);
    int nb;
    nb = (n == 0 || n > NT) ? NT : n;
    for (int i = 0; i < nb; i++) begin
      int   k;
      exp_t e;
      k      = rev ? (nb - 1 - i) : i;
      e.data = v[k*DW +: DW];
      e.strb = s[k*SW +: SW];
      e.last = (i == nb - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic clear_logs();
    beat_cyc.delete();
    beat_data.delete();
    done_cnt = 0;
    busy_cnt = 0;
  endtask

  // Holds valid with the given vector until accepted; returns the cycle of
  // the accepting edge's preceding negedge. Leaves valid high on return.
  task automatic present(input logic [DW*NT-1:0] v, input logic [SW*NT-1:0] s,
                         input int n, input bit rev, output int acc);
    bit got;
    int g;
    got = 1'b0;
    g   = 0;
    acc = -1;
    par_valid = 1'b1;
    par_data  = v;
    par_strb  = s;
    nb_taps_i = CW'(n);
    reverse_i = rev;
    while (!got && g < 200) begin
      @(negedge clk_i);
      if (par_ready) begin
        got = 1'b1;
        acc = cyc;
        model_push(v, s, n, rev);
      end
      @(posedge clk_i); #1;
      g++;
    end
    if (!got) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 3000) begin
      @(posedge clk_i);
      g++;
    end
    check("drain", exp_q.size(), 0);
    repeat (3) @(posedge clk_i);
    #1;
  endtask

  task automatic wait_beats(input int n);
    int g;
    g = 0;
    while (beat_cyc.size() < n && g < 50) begin
      @(posedge clk_i); #1;
      g++;
    end
    check("wait_beats", beat_cyc.size(), n);
  endtask

  // Serial-side backpressure driver.
  initial begin
    forever begin
      @(posedge clk_i); #1;
      ser_ready = stall_mode ? ($urandom_range(0, 9) != 0) : 1'b1;
    end
  end

  // Monitor: compares every serial handshake against the scoreboard.
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic [SW-1:0] prev_strb;
  exp_t          mon_e;
  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stable_valid", ser_valid, 1'b1);
          check("stable_data", ser_data, prev_data);
          check("stable_strb", ser_strb, prev_strb);
        end
        check("busy_eq_valid", busy, ser_valid);
        if (busy) busy_cnt++;
        if (clear_i) begin
          check("done_in_clear", done, 1'b0);
        end else if (ser_valid && ser_ready) begin
          beat_cyc.push_back(cyc);
          beat_data.push_back(ser_data);
          if (done) done_cnt++;
          if (exp_q.size() == 0) begin
            check("unexpected_beat", ser_data, 64'hDEAD);
          end else begin
            mon_e = exp_q.pop_front();
            check("ser_data", ser_data, mon_e.data);
            check("ser_strb", ser_strb, mon_e.strb);
            check("done_on_beat", done, mon_e.last);
          end
        end else begin
          check("done_idle", done, 1'b0);
        end
        prev_stall = ser_valid && !ser_ready && !clear_i;
        prev_data  = ser_data;
        prev_strb  = ser_strb;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  logic [DW*NT-1:0] vec_a;
  logic [DW*NT-1:0] vec_b;
  logic [DW*NT-1:0] rv;
  logic [SW*NT-1:0] rs;
  int               acc0;
  int               acc1;

  initial begin
    vec_a = 64'h0004_0003_0002_0001;
    vec_b = 64'h00B4_00B3_00B2_00B1;

    // Reset state
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_valid", ser_valid, 1'b0);
    check("rst_data", ser_data, 0);
    check("rst_strb", ser_strb, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ready", par_ready, 1'b1);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("post_rst_ready", par_ready, 1'b1);
    @(posedge clk_i); #1;

    // Forward, full count, no stalls
    clear_logs();
    present(vec_a, '1, 0, 1'b0, acc0);
    par_valid = 1'b0;
    wait_drain();
    check("fwd_beats", beat_cyc.size(), 4);
    if (beat_cyc.size() == 4) begin
      check("fwd_first_cyc", beat_cyc[0], acc0 + 1);
      check("fwd_last_cyc", beat_cyc[3], acc0 + 4);
      check("fwd_d0", beat_data[0], 16'h0001);
      check("fwd_d3", beat_data[3], 16'h0004);
    end
    check("fwd_done_cnt", done_cnt, 1);
    check("fwd_busy_cycles", busy_cnt, 4);

    // Reverse, partial count
    clear_logs();
    present(vec_a, '1, 3, 1'b1, acc0);
    par_valid = 1'b0;
    nb_taps_i = CW'(1);
    reverse_i = 1'b0;
    wait_drain();
    check("rev_beats", beat_cyc.size(), 3);
    if (beat_cyc.size() == 3) begin
      check("rev_d0", beat_data[0], 16'h0003);
      check("rev_d1", beat_data[1], 16'h0002);
      check("rev_d2", beat_data[2], 16'h0001);
    end
    check("rev_done_cnt", done_cnt, 1);

    // Back-to-back vectors
    clear_logs();
    present(vec_a, '1, 0, 1'b0, acc0);
    present(vec_b, '1, 0, 1'b0, acc1);
    par_valid = 1'b0;
    wait_drain();
    check("b2b_accept_gap", acc1 - acc0, 4);
    check("b2b_beats", beat_cyc.size(), 8);
    if (beat_cyc.size() == 8) begin
      check("b2b_no_bubble", beat_cyc[7] - beat_cyc[0], 7);
      check("b2b_second_first", beat_data[4], 16'h00B1);
    end
    check("b2b_done_cnt", done_cnt, 2);

    // Clear after two words
    clear_logs();
    present(vec_a, '1, 0, 1'b0, acc0);
    par_valid = 1'b0;
    wait_beats(2);
    clear_i = 1'b1;
    exp_q.delete();
    @(negedge clk_i);
    check("clr_ready_forced", par_ready, 1'b0);
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    @(negedge clk_i);
    check("clr_valid", ser_valid, 1'b0);
    check("clr_busy", busy, 1'b0);
    check("clr_no_done", done_cnt, 0);
    check("clr_beats", beat_cyc.size(), 2);
    @(posedge clk_i); #1;
    clear_logs();
    present(vec_b, '1, 0, 1'b0, acc0);
    par_valid = 1'b0;
    wait_drain();
    check("clr_restart_beats", beat_cyc.size(), 4);
    if (beat_cyc.size() == 4) check("clr_restart_w0", beat_data[0], 16'h00B1);

    // Saturating count
    clear_logs();
    present(vec_a, '1, 7, 1'b0, acc0);
    par_valid = 1'b0;
    wait_drain();
    check("sat_beats", beat_cyc.size(), 4);
    if (beat_cyc.size() == 4) check("sat_d3", beat_data[3], 16'h0004);

    // Asynchronous reset mid-vector
    clear_logs();
    present(vec_a, '1, 0, 1'b0, acc0);
    par_valid = 1'b0;
    wait_beats(2);
    rst_ni = 1'b0;
    exp_q.delete();
    #1;
    check("arst_valid", ser_valid, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_data", ser_data, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("arst_ready", par_ready, 1'b1);
    check("arst_valid_after", ser_valid, 1'b0);
    @(posedge clk_i); #1;

    // Randomised traffic with stalls on both sides
    stall_mode = 1'b1;
    for (int n = 0; n < 512; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        par_valid = 1'b0;
        nb_taps_i = CW'($urandom_range(0, 7));
        reverse_i = 1'($urandom_range(0, 1));
        @(posedge clk_i); #1;
      end
      for (int k = 0; k < NT; k++) rv[k*DW +: DW] = DW'($urandom);
      rs = SW*NT'($urandom);
      present(rv, rs, $urandom_range(0, 7), 1'($urandom_range(0, 1)), acc0);
    end
    par_valid = 1'b0;
    wait_drain();
    stall_mode = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
